operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: XLEN, default 32, data width of register values and operands.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid_i / in_ready_o  input / output  1 / 1  issue handshake; transfer when both are high.
REQ-005 in_rs1_i, in_rs2_i, in_rd_i  input  5 each  source and destination register indices of the issued instruction.
REQ-006 in_rd_we_i  input  1  issued instruction writes in_rd_i.
REQ-007 sel_rs1_o, sel_rs2_o  output  5 each  read selects to the register file, combinationally equal to in_rs1_i / in_rs2_i.
REQ-008 rf_rs1_i, rf_rs2_i  input  XLEN each  register-file read data, valid one cycle after the select.
REQ-009 rf_sel_rs1_i, rf_sel_rs2_i  input  5 each  register-file echo of the index that produced rf_rs1_i / rf_rs2_i.
REQ-010 wb_valid_i, wb_rd_i, wb_data_i  input  1 / 5 / XLEN  writeback port, the same write presented to the register file this cycle.
REQ-011 out_valid_o / out_ready_i  output / input  1 / 1  operand handshake to execute.
REQ-012 out_rs1_o, out_rs2_o  output  XLEN each  resolved operand values.
REQ-013 out_rd_o, out_rd_we_o  output  5 / 1  destination index and write enable carried with the operands.
REQ-014 pending_o  output  32  scoreboard; bit n set means register n has an outstanding write.
REQ-015 err_o  output  1  sticky select-echo mismatch flag; present only with OPFETCH_CHECK_EN.

Function
REQ-016 Hazard is asserted when (in_rs1_i!=0 and pend_eff[in_rs1_i]), (in_rs2_i!=0 and pend_eff[in_rs2_i]), or (in_rd_we_i and in_rd_i!=0 and pend_eff[in_rd_i]); pend_eff is pending_o with this cycle's wb_rd_i bit cleared when wb_valid_i is high.
REQ-017 in_ready_o = (!out_valid_o or out_ready_i) and !hazard; it is combinational and independent of in_valid_i.
REQ-018 On accept, out_valid_o rises at the next edge and out_rd_o / out_rd_we_o take the issued values; latency is one cycle, and throughput is one instruction per cycle.
REQ-019 In the first valid cycle, out_rsN_o = 0 if the index is 0, otherwise the bypass-captured value (REQ-020) if one was captured, otherwise rf_rsN_i.
REQ-020 A bypass capture occurs when wb_valid_i is high in the accept cycle, wb_rd_i equals the source index, and the index is non-zero; wb_data_i is registered in that case.
REQ-021 While out_valid_o is high and out_ready_i is low, all out_* values hold stable, and operands are latched internally after the first valid cycle.
REQ-022 out_valid_o clears at an edge where out_ready_i is high and no new accept occurs.
REQ-023 Scoreboard updates: wb_valid_i clears pending[wb_rd_i]; an accept with in_rd_we_i and in_rd_i!=0 sets pending[in_rd_i]; when both target the same bit in one cycle, set wins.
REQ-024 pending_o[0] is constantly 0.
REQ-025 A writeback to a non-pending register is ignored by the scoreboard and produces no error.

Reset
REQ-026 Asserting rst_n low, at any time including mid-handshake, immediately forces out_valid_o=0, out_rs1_o=out_rs2_o=0, out_rd_o=0, out_rd_we_o=0, pending_o=0, err_o=0, and discards the in-flight instruction.
REQ-027 After rst_n deasserts, in_ready_o is high in the first cycle.

Configuration
REQ-028 With OPFETCH_CHECK_EN defined, err_o sets and stays set until reset whenever, in the first valid cycle, rf_sel_rs1_i or rf_sel_rs2_i differs from the latched source index.
REQ-029 Without OPFETCH_CHECK_EN, the err_o port and the check logic are absent, and all other behaviour is identical.

Verification
REQ-030 Reset, write x5=0x1234 via wb, then issue rs1=5, rs2=0 -> out_rs1_o=0x1234 and out_rs2_o=0 one cycle after accept.
REQ-031 Issue rd=7 with rd_we=1, then issue rs1=7 -> in_ready_o low until wb_rd=7 arrives; in that wb cycle accept occurs, and out_rs1_o equals wb_data_i via bypass.
REQ-032 Issue three back-to-back instructions with out_ready_i=1 -> three accepts on consecutive cycles and out_valid_o high for three cycles.
REQ-033 Hold out_ready_i=0 for 4 cycles with x3 changing in the register file -> out_* frozen and in_ready_o=0 throughout.
REQ-034 Issue rd=9 with rd_we=1 while wb_rd=9 is the same cycle -> pending_o[9]=1 afterwards.
REQ-035 With OPFETCH_CHECK_EN, force rf_sel_rs1_i=4 when index 3 is expected -> err_o=1 until rst_n is pulsed low.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: hazard scoreboard, writeback bypass capture, and operand skid latching.
// Optional macro OPFETCH_CHECK_EN adds err_o, a sticky register-file select-echo check.
module operand_fetch #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [4:0]      in_rs1_i,
  input  logic [4:0]      in_rs2_i,
  input  logic [4:0]      in_rd_i,
  input  logic            in_rd_we_i,
  output logic [4:0]      sel_rs1_o,
  output logic [4:0]      sel_rs2_o,
  input  logic [XLEN-1:0] rf_rs1_i,
  input  logic [XLEN-1:0] rf_rs2_i,
  input  logic [4:0]      rf_sel_rs1_i,
  input  logic [4:0]      rf_sel_rs2_i,
  input  logic            wb_valid_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_rs1_o,
  output logic [XLEN-1:0] out_rs2_o,
  output logic [4:0]      out_rd_o,
  output logic            out_rd_we_o,
  output logic [31:0]     pending_o
`ifdef OPFETCH_CHECK_EN
  ,
  output logic            err_o
`endif
);

  function automatic logic [XLEN-1:0] resolve_src(input logic [4:0] idx, input logic hit,
                                                  input logic [XLEN-1:0] byp, input logic [XLEN-1:0] rf);
    if (idx == 5'd0) begin
      resolve_src = {XLEN{1'b0}};
    end else if (hit) begin
      resolve_src = byp;
    end else begin
      resolve_src = rf;
    end
  endfunction

  logic            out_valid_q, out_valid_d;
  logic            first_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic            rd_we_q;
  logic            hit1_q, hit2_q;
  logic [XLEN-1:0] byp1_q, byp2_q;
  logic [XLEN-1:0] op1_q, op2_q;
  logic [31:0]     pending_q, pending_d;
  logic [31:0]     pend_eff_s;
  logic            hazard_s;
  logic            in_ready_s;
  logic            accept_s;
  logic [XLEN-1:0] rs1_val_s, rs2_val_s;

  // Hazard detection against the scoreboard as it will look after this cycle's writeback.
  always_comb begin
    pend_eff_s = pending_q;
    if (wb_valid_i) begin
      pend_eff_s[wb_rd_i] = 1'b0;
    end else begin
      pend_eff_s = pending_q;
    end
    hazard_s = ((in_rs1_i != 5'd0) && pend_eff_s[in_rs1_i]) ||
               ((in_rs2_i != 5'd0) && pend_eff_s[in_rs2_i]) ||
               (in_rd_we_i && (in_rd_i != 5'd0) && pend_eff_s[in_rd_i]);
    in_ready_s = (!out_valid_q || out_ready_i) && !hazard_s;
    accept_s   = in_valid_i && in_ready_s;
  end

  // Next scoreboard and output-valid state; a same-cycle set beats the writeback clear.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid_i) begin
      pending_d[wb_rd_i] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (accept_s && in_rd_we_i && (in_rd_i != 5'd0)) begin
      pending_d[in_rd_i] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
    pending_d[0] = 1'b0;

    if (accept_s) begin
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Operand values in the first valid cycle come straight from the register file or the bypass.
  always_comb begin
    rs1_val_s = resolve_src(rs1_q, hit1_q, byp1_q, rf_rs1_i);
    rs2_val_s = resolve_src(rs2_q, hit2_q, byp2_q, rf_rs2_i);
  end

  // Pipeline, bypass capture and operand latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      first_q     <= 1'b0;
      rd_q        <= 5'd0;
      rd_we_q     <= 1'b0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      byp1_q      <= {XLEN{1'b0}};
      byp2_q      <= {XLEN{1'b0}};
      op1_q       <= {XLEN{1'b0}};
      op2_q       <= {XLEN{1'b0}};
      pending_q   <= 32'd0;
    end else begin
      out_valid_q <= out_valid_d;
      first_q     <= accept_s;
      pending_q   <= pending_d;
      if (accept_s) begin
        rd_q    <= in_rd_i;
        rd_we_q <= in_rd_we_i;
        rs1_q   <= in_rs1_i;
        rs2_q   <= in_rs2_i;
        hit1_q  <= wb_valid_i && (wb_rd_i == in_rs1_i) && (in_rs1_i != 5'd0);
        hit2_q  <= wb_valid_i && (wb_rd_i == in_rs2_i) && (in_rs2_i != 5'd0);
        byp1_q  <= wb_data_i;
        byp2_q  <= wb_data_i;
      end
      // Freeze the register-file data once it has been seen, so later RF reads cannot disturb it.
      if (first_q) begin
        op1_q <= rs1_val_s;
        op2_q <= rs2_val_s;
      end
    end
  end

`ifdef OPFETCH_CHECK_EN
  logic err_q;

  // Sticky flag for a register-file echo that disagrees with the index we asked for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (first_q && ((rf_sel_rs1_i != rs1_q) || (rf_sel_rs2_i != rs2_q))) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_sel_s;
  assign unused_sel_s = ^{rf_sel_rs1_i, rf_sel_rs2_i};
`endif

  assign in_ready_o  = in_ready_s;
  assign sel_rs1_o   = in_rs1_i;
  assign sel_rs2_o   = in_rs2_i;
  assign out_valid_o = out_valid_q;
  assign out_rs1_o   = first_q ? rs1_val_s : op1_q;
  assign out_rs2_o   = first_q ? rs2_val_s : op2_q;
  assign out_rd_o    = rd_q;
  assign out_rd_we_o = rd_we_q;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic against an
// architectural model (register contents, outstanding-write set, one pending output slot).
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i, in_ready_o;
  logic [4:0]  in_rs1_i, in_rs2_i, in_rd_i;
  logic        in_rd_we_i;
  logic [4:0]  sel_rs1_o, sel_rs2_o;
  logic [31:0] rf_rs1_i, rf_rs2_i;
  logic [4:0]  rf_sel_rs1_i, rf_sel_rs2_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] out_rs1_o, out_rs2_o;
  logic [4:0]  out_rd_o;
  logic        out_rd_we_o;
  logic [31:0] pending_o;
`ifdef OPFETCH_CHECK_EN
  logic        err_o;
`endif

  operand_fetch #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rd_i(in_rd_i), .in_rd_we_i(in_rd_we_i),
    .sel_rs1_o(sel_rs1_o), .sel_rs2_o(sel_rs2_o),
    .rf_rs1_i(rf_rs1_i), .rf_rs2_i(rf_rs2_i),
    .rf_sel_rs1_i(rf_sel_rs1_i), .rf_sel_rs2_i(rf_sel_rs2_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o),
    .out_rd_o(out_rd_o), .out_rd_we_o(out_rd_we_o),
    .pending_o(pending_o)
`ifdef OPFETCH_CHECK_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk = ~clk;

  // Register file stand-in: synchronous read one cycle after select, write at the edge.
  logic [31:0] rf_mem [32];
  logic        bad_sel = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= $urandom;
    end else if (wb_valid_i) begin
      rf_mem[wb_rd_i] <= wb_data_i;
    end
    rf_rs1_i     <= rf_mem[sel_rs1_o];
    rf_rs2_i     <= rf_mem[sel_rs2_o];
    rf_sel_rs1_i <= bad_sel ? 5'd4 : sel_rs1_o;
    rf_sel_rs2_i <= sel_rs2_o;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural model
  logic        m_valid = 1'b0;
  logic [31:0] m_rs1, m_rs2, m_pend = 32'd0;
  logic [4:0]  m_rd;
  logic        m_we;

  function automatic logic [31:0] arch_val(input logic [4:0] r, input logic wv,
                                           input logic [4:0] wrd, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (wv && wrd == r) return wd;
    return rf_mem[r];
  endfunction

  // One clock cycle: drive, check at negedge, advance model at posedge; returns sampled ready.
  task automatic step(input logic iv, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input logic we, input logic ordy, input logic wv, input logic [4:0] wrd,
                      input logic [31:0] wd, output logic rdy);
    logic [31:0] peff, v1, v2;
    logic hz, exp_rdy, acc;
    in_valid_i = iv; in_rs1_i = r1; in_rs2_i = r2; in_rd_i = rd; in_rd_we_i = we;
    out_ready_i = ordy; wb_valid_i = wv; wb_rd_i = wrd; wb_data_i = wd;
    @(negedge clk);
    peff = m_pend;
    if (wv) peff[wrd] = 1'b0;
    hz = (r1 != 5'd0 && peff[r1]) || (r2 != 5'd0 && peff[r2]) || (we && rd != 5'd0 && peff[rd]);
    exp_rdy = (!m_valid || ordy) && !hz;
    rdy = in_ready_o;
    chk_eq("in_ready", {63'd0, in_ready_o}, {63'd0, exp_rdy});
    chk_eq("pending", {32'd0, pending_o}, {32'd0, m_pend});
    chk_eq("out_valid", {63'd0, out_valid_o}, {63'd0, m_valid});
    chk_eq("sel_rs1", {59'd0, sel_rs1_o}, {59'd0, r1});
    if (m_valid) begin
      chk_eq("out_rs1", {32'd0, out_rs1_o}, {32'd0, m_rs1});
      chk_eq("out_rs2", {32'd0, out_rs2_o}, {32'd0, m_rs2});
      chk_eq("out_rd", {59'd0, out_rd_o}, {59'd0, m_rd});
      chk_eq("out_rd_we", {63'd0, out_rd_we_o}, {63'd0, m_we});
    end
    acc = iv && exp_rdy;
    v1 = arch_val(r1, wv, wrd, wd);
    v2 = arch_val(r2, wv, wrd, wd);
    @(posedge clk);
    if (wv) m_pend[wrd] = 1'b0;
    if (acc && we && rd != 5'd0) m_pend[rd] = 1'b1;
    m_pend[0] = 1'b0;
    if (acc) begin
      m_valid = 1'b1; m_rs1 = v1; m_rs2 = v2; m_rd = rd; m_we = we;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input logic ordy, output logic rdy);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, ordy, 1'b0, 5'd0, 32'd0, rdy);
  endtask

  initial begin
    logic rdy;
    logic [4:0] cand [$];
    logic [4:0] wrd;
    logic wv;
    rst_n = 1'b0;
    in_valid_i = 1'b0; in_rs1_i = 5'd0; in_rs2_i = 5'd0; in_rd_i = 5'd0; in_rd_we_i = 1'b0;
    out_ready_i = 1'b0; wb_valid_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk_eq("rst_pending", {32'd0, pending_o}, 64'd0);
    chk_eq("rst_out_rs1", {32'd0, out_rs1_o}, 64'd0);
    rst_n = 1'b1;

    // First cycle after reset: ready with nothing outstanding
    idle(1'b1, rdy);
    chk_eq("post_rst_ready", {63'd0, rdy}, 64'd1);

    // Write x5 then read it with rs2 = x0
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1234, rdy);
    step(1'b1, 5'd5, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    chk_eq("x5_rs1", {32'd0, out_rs1_o}, 64'h1234);
    chk_eq("x5_rs2", {32'd0, out_rs2_o}, 64'd0);
    idle(1'b1, rdy);

    // RAW on x7: blocked until the writeback, accepted with bypass in that cycle
    step(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd7, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
      chk_eq("raw_blocked", {63'd0, rdy}, 64'd0);
    end
    step(1'b1, 5'd7, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 5'd7, 32'hCAFE_0007, rdy);
    chk_eq("raw_wb_ready", {63'd0, rdy}, 64'd1);
    chk_eq("raw_bypass", {32'd0, out_rs1_o}, 64'hCAFE_0007);

    // Three back-to-back accepts
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'(10 + i), 5'(20 + i), 5'(11 + i), 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
      chk_eq("b2b_accept", {63'd0, rdy}, 64'd1);
    end
    idle(1'b1, rdy);

    // Stall 4 cycles while x3 changes underneath
    step(1'b1, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1, 5'd3, $urandom, rdy);
      chk_eq("stall_ready", {63'd0, rdy}, 64'd0);
    end
    idle(1'b1, rdy);
    idle(1'b1, rdy);

    // Set and writeback of x9 in the same cycle: set wins
    step(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 32'h99, rdy);
    chk_eq("same_cycle_set", {63'd0, pending_o[9]}, 64'd1);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h9999, rdy);

    // Asynchronous reset mid-handshake
    step(1'b1, 5'd2, 5'd3, 5'd12, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_valid", {63'd0, out_valid_o}, 64'd0);
    chk_eq("mid_rst_rs", {out_rs1_o, out_rs2_o}, 64'd0);
    chk_eq("mid_rst_rd", {58'd0, out_rd_o, out_rd_we_o}, 64'd0);
    chk_eq("mid_rst_pend", {32'd0, pending_o}, 64'd0);
    m_valid = 1'b0; m_pend = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1'b1, rdy);
    chk_eq("mid_rst_ready", {63'd0, rdy}, 64'd1);

`ifdef OPFETCH_CHECK_EN
    chk_eq("err_clean", {63'd0, err_o}, 64'd0);
    bad_sel = 1'b1;
    step(1'b1, 5'd3, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
    bad_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, rdy);
      chk_eq("err_sticky", {63'd0, err_o}, 64'd1);
    end
    rst_n = 1'b0;
    #1 chk_eq("err_cleared", {63'd0, err_o}, 64'd0);
    m_valid = 1'b0; m_pend = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
`endif

    // Randomized traffic, small register window to force hazards
    for (int n = 0; n < 600; n++) begin
      cand.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r]) cand.push_back(5'(r));
      wv = 1'b0; wrd = 5'd0;
      if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
        wv = 1'b1; wrd = cand[$urandom_range(0, cand.size() - 1)];
      end else if ($urandom_range(0, 7) == 0) begin
        wv = 1'b1; wrd = 5'($urandom_range(1, 31));
      end
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           wv, wrd, $urandom, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
